// File: rtl/prog_loader.sv
// Boot-time program loader: turns a little-endian byte stream (word count, then words)
// into instruction-memory writes and holds the CPU in reset until the load completes.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte moves only on a cycle where byte_valid and byte_ready are both 1;
  // byte_ready depends on state alone, never on byte_valid.
  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] word_q;
  logic [31:0] n_q;
  logic [31:0] word_idx;
  logic [31:0] full_word;
  logic        xfer;

  // The word as it will look once the byte on the bus lands in the top lane.
  assign full_word = {byte_data, word_q[23:0]};
  assign xfer      = byte_valid & byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR;
      byte_cnt <= 2'd0;
      word_q   <= 32'd0;
      n_q      <= 32'd0;
      word_idx <= 32'd0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        word_q[{byte_cnt, 3'b000} +: 8] <= byte_data;
        byte_cnt                         <= byte_cnt + 2'd1;
        if (state == S_HDR && byte_cnt == 2'd3) n_q <= full_word;
      end
      if (state == S_WRITE) word_idx <= word_idx + 32'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_rst    = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_HDR: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) begin
          if (full_word == 32'd0)           state_nx = S_DONE;
          else if (full_word > MEM_WORDS_W) state_nx = S_ERR;
          else                              state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        imem_we  = 1'b1;
        state_nx = (word_idx + 32'd1 == n_q) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: state_nx = S_HDR;
    endcase
  end

  // Address and data track the registers in every state so they are never X.
  assign imem_addr  = ADDR_WIDTH'({word_idx, 2'b00});
  assign imem_wdata = DATA_WIDTH'(word_q);
  assign dbg_state  = state;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: byte-count reference model plus a write scoreboard,
// with literal expectations for the reference streams.
module tb_prog_loader;
  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_rst, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  prog_loader #(.DATA_WIDTH(32), .MEM_WORDS(MW), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  stream[$];
  int          ptr;
  logic [31:0] exp_q[$];
  logic [31:0] log_addr[$], log_data[$];

  // Reference model: counts of bytes taken and words written.
  int          m_bc, m_written, m_consumed;
  logic [31:0] m_asm, m_n;
  bit          m_hdr_done, m_pend;

  function automatic bit m_err();
    return m_hdr_done && (m_n > 32'(MW));
  endfunction

  function automatic bit m_done();
    return m_hdr_done && (m_n <= 32'(MW)) && (32'(m_written) == m_n) && !m_pend;
  endfunction

  function automatic bit m_ready();
    return !m_pend && !m_err() && !m_done();
  endfunction

  task automatic m_clear();
    m_bc = 0; m_written = 0; m_consumed = 0; m_asm = '0; m_n = '0;
    m_hdr_done = 0; m_pend = 0;
    exp_q.delete();
  endtask

  task automatic m_update(input logic r, input bit x, input logic [7:0] b);
    if (r) m_clear();
    else if (x) begin
      m_asm = {b, m_asm[31:8]};
      m_consumed++;
      if (m_bc == 3) begin
        if (!m_hdr_done) begin m_n = m_asm; m_hdr_done = 1; end
        else begin m_pend = 1; exp_q.push_back(m_asm); end
        m_bc = 0;
      end else m_bc++;
    end else if (m_pend) begin
      m_pend = 0;
      m_written++;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e;
    chk("byte_ready", 64'(byte_ready), 64'(m_ready()));
    chk("imem_we", 64'(imem_we), 64'(m_pend));
    chk("cpu_rst", 64'(cpu_rst), 64'(!m_done()));
    chk("done", 64'(done), 64'(m_done()));
    chk("error", 64'(error), 64'(m_err()));
    chk("addr_data_known", 64'($isunknown({imem_addr, imem_wdata})), 64'(0));
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("imem_wdata", 64'(imem_wdata), 64'(e));
        chk("imem_addr", 64'(imem_addr), 64'(32'(4 * m_written)));
      end
    end
  endtask

  // One cycle: check outputs, drive inputs, advance the model across the edge.
  task automatic step(input bit v, input bit r);
    bit x;
    check_outputs();
    rst        = r;
    byte_valid = v;
    byte_data  = (ptr < stream.size()) ? stream[ptr] : 8'($urandom_range(0, 255));
    x = v && m_ready() && !r;
    @(posedge clk);
    m_update(r, x, byte_data);
    if (x) ptr++;
    @(negedge clk);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream.push_back(8'(w >> (8 * i)));
  endtask

  task automatic new_stream(input int n, input int words);
    stream.delete();
    ptr = 0;
    add_word(32'(n));
    for (int i = 0; i < words; i++) add_word($urandom());
  endtask

  task automatic do_reset();
    step(0, 1);
    step(0, 1);
    log_addr.delete();
    log_data.delete();
  endtask

  // mode 0: valid always, 1: toggling, 2: random. Stops a few cycles after done/error.
  task automatic run(input int mode, input int budget);
    int extra;
    bit v;
    extra = 0;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       v = 1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      step(v, 0);
      if (m_done() || m_err()) begin
        extra++;
        if (extra > 4) begin
          chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
          return;
        end
      end
    end
    n_cmp++; n_fail++;
    $display("FAIL timeout: load not finished within %0d cycles", budget);
  endtask

  initial begin
    rst = 1; byte_valid = 0; byte_data = 0; ptr = 0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_byte_ready", 64'(byte_ready), 64'(1));
    chk("rst_imem_we", 64'(imem_we), 64'(0));
    chk("rst_imem_addr", 64'(imem_addr), 64'(0));
    chk("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    chk("rst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));

    // Reference two-word program.
    do_reset();
    stream = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
              8'h93, 8'h05, 8'h10, 8'h00};
    ptr = 0;
    run(0, 100);
    chk("ref_write_count", 64'(log_addr.size()), 64'(2));
    if (log_addr.size() == 2) begin
      chk("ref_addr0", 64'(log_addr[0]), 64'(32'h0));
      chk("ref_data0", 64'(log_data[0]), 64'(32'h0050_0513));
      chk("ref_addr1", 64'(log_addr[1]), 64'(32'h4));
      chk("ref_data1", 64'(log_data[1]), 64'(32'h0010_0593));
    end
    chk("ref_done", 64'(done), 64'(1));
    chk("ref_cpu_rst", 64'(cpu_rst), 64'(0));

    // Empty program.
    do_reset();
    new_stream(0, 0);
    run(0, 50);
    chk("empty_writes", 64'(log_addr.size()), 64'(0));
    chk("empty_done", 64'(done), 64'(1));

    // Oversized header.
    do_reset();
    new_stream(MW + 1, 0);
    run(0, 50);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("err_error", 64'(error), 64'(1));
    chk("err_ready", 64'(byte_ready), 64'(0));
    chk("err_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("err_writes", 64'(log_addr.size()), 64'(0));

    // Single word, valid toggling.
    do_reset();
    stream.delete(); ptr = 0;
    add_word(32'd1); add_word(32'hDEAD_BEEF);
    run(1, 100);
    chk("toggle_writes", 64'(log_addr.size()), 64'(1));
    if (log_addr.size() == 1) begin
      chk("toggle_addr", 64'(log_addr[0]), 64'(0));
      chk("toggle_data", 64'(log_data[0]), 64'(32'hDEAD_BEEF));
    end

    // Reset after 6 bytes of a 3-word load, reset coincides with a valid byte.
    do_reset();
    new_stream(3, 3);
    for (int i = 0; i < 40 && m_consumed < 6; i++) step(1, 0);
    stream.delete(); ptr = 0;
    add_word(32'd1); add_word(32'h1234_5678);
    log_addr.delete(); log_data.delete();
    step(1, 1);
    run(0, 100);
    chk("restart_writes", 64'(log_addr.size()), 64'(1));
    if (log_addr.size() == 1) begin
      chk("restart_addr", 64'(log_addr[0]), 64'(0));
      chk("restart_data", 64'(log_data[0]), 64'(32'h1234_5678));
    end
    chk("restart_done", 64'(done), 64'(1));

    // Full memory.
    do_reset();
    new_stream(MW, MW);
    run(2, 600);
    chk("full_writes", 64'(log_addr.size()), 64'(MW));
    if (log_addr.size() == MW) chk("full_last_addr", 64'(log_addr[MW-1]), 64'(4 * (MW - 1)));
    chk("full_done", 64'(done), 64'(1));

    // Random loads.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(0, MW + 2);
      do_reset();
      new_stream(n, (n > MW) ? 0 : n);
      run($urandom_range(0, 2), 600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
